data_mem_seq: RTL and testbench
===============================

// Module: data_mem_seq
// PURPOSE
//  - Parametrised successor to the 8-bit/32-word data memory: configurable width and depth, registered read, self-initialising.
//  - After reset, a sequencer walks every word and loads the preset table (DATA_1/DATA_2/TEMP) or zero, then asserts ready.
//  - Sits between the CPU datapath (load/store) and the register file.
// PARAMETERS
//  - DATA_W  8   word width in bits
//  - DEPTH   32  number of words; any value 2..256, need not be a power of 2
//  - ADDR_W  $clog2(DEPTH)  address width; derived, do not override
// PORTS
//  - clock        in   1       single clock; all state on rising edge
//  - reset        in   1       asynchronous, active-low (0 = reset)
//  - wr_en        in   1       write strobe, sampled when ready=1
//  - rd_en        in   1       read strobe, sampled when ready=1
//  - addr         in   ADDR_W  word address for read and write
//  - wdata        in   DATA_W  write data
//  - rdata        out  DATA_W  read data, registered
//  - rdata_valid  out  1       rdata holds the result of the previous cycle's read
//  - ready        out  1       initialisation complete; accesses accepted
//  - addr_err     out  1       one-cycle pulse: accepted access had addr >= DEPTH
// BEHAVIOUR
//  - Reset (reset=0, asynchronous):
//    - rdata=0, rdata_valid=0, ready=0, addr_err=0
//    - state=INIT, init counter=0
//    - Array contents are undefined until INIT completes.
//  - FSM states: INIT -> IDLE. There is no other state and no return to INIT except via reset.
//  - INIT:
//    - Each cycle writes mem[cnt] = PRESET(cnt), then increments cnt.
//    - On cnt==DEPTH-1, transition to IDLE and set ready=1 on the same edge.
//    - ready therefore rises DEPTH clock edges after reset release.
//    - wr_en and rd_en are ignored; rdata_valid stays 0.
//  - Reset asserted mid-INIT aborts it; the count restarts from 0 after release.
//  - IDLE write: when wr_en=1 and addr<DEPTH, mem[addr]<=wdata at the edge.
//  - IDLE read:
//    - When rd_en=1 and addr<DEPTH: rdata<=mem[addr] and rdata_valid<=1 at the edge (latency 1).
//    - Otherwise rdata_valid<=0 and rdata holds its value.
//  - wr_en and rd_en together at the same addr: read-first, so rdata returns the OLD word and the write still lands.
//  - addr>=DEPTH (only possible when DEPTH is not a power of 2):
//    - The access is dropped, with no array change.
//    - A read returns rdata=0 with rdata_valid=1.
//    - addr_err pulses high for 1 cycle.
//  - Widths: addr is unsigned. Preset values wider than DATA_W are truncated; narrower values are zero-extended.
// CONFIGURATION
//  - Macro DATA_MEM_PARITY_EN:
//    - Defined:
//      - Each word stores an extra even-parity bit, computed on every write (including INIT).
//      - Extra output par_err (1 bit, reset 0) is registered alongside rdata.
//      - par_err=1 with rdata_valid=1 when the stored parity mismatches the stored data.
//      - Includes an input inj_par (1 bit): when high during a write, the stored parity bit is inverted (test hook).
//    - Undefined: no parity storage, no par_err/inj_par ports, behaviour otherwise identical.
// STRUCTURE
//  - Package data_mem_pkg:
//    - State enum {ST_INIT, ST_IDLE}.
//    - Preset table constants: ADDR_DATA_1=5'h1A/8'h00, ADDR_DATA_2=5'h1B/8'hFF, ADDR_TEMP=5'h1C/8'hAA.
//    - Function preset_val(addr) returning the table value, else 0.
//  - Preset entries with address >= DEPTH are skipped.
//  - Sub-module data_mem_init_seq: INIT counter, FSM and the ready flag.
//  - The top level holds the array, the read register and the error logic.
// TESTING
//  - Init, DEPTH=32, DATA_W=8:
//    - Release reset, then ready rises exactly 32 edges later.
//    - Reads of 0x1A/0x1B/0x1C return 00/FF/AA.
//    - Read of 0x05 returns 00.
//  - Write/read:
//    - wr 0x1C<=5A, then rd 0x1C: the next cycle gives rdata=5A, rdata_valid=1.
//    - An idle cycle after that gives rdata_valid=0 with rdata held at 5A.
//  - Read-first:
//    - wr_en=rd_en=1 at 0x1B, wdata=3C: rdata=FF.
//    - A subsequent read returns 3C.
//  - Reset mid-INIT:
//    - Assert reset at INIT cycle 10, release.
//    - ready rises 32 edges after the second release.
//    - wr 0x00 during INIT is ignored: reading 0x00 returns 00.
//  - Range, DEPTH=20 (ADDR_W=5):
//    - rd 0x17 returns rdata=00, rdata_valid=1, addr_err pulse.
//    - wr 0x17 gives an addr_err pulse and leaves mem[0x03] unchanged.
//  - DATA_MEM_PARITY_EN:
//    - wr 0x02<=81 with inj_par=1, then rd 0x02: par_err=1.
//    - Rewrite with inj_par=0: par_err=0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and preset table for the self-initialising data memory.
// The preset table is expressed in 8-bit values; the top level truncates or
// zero-extends them to its configured word width.
package data_mem_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  localparam logic [4:0] ADDR_DATA_1 = 5'h1A;
  localparam logic [7:0] VAL_DATA_1  = 8'h00;
  localparam logic [4:0] ADDR_DATA_2 = 5'h1B;
  localparam logic [7:0] VAL_DATA_2  = 8'hFF;
  localparam logic [4:0] ADDR_TEMP   = 5'h1C;
  localparam logic [7:0] VAL_TEMP    = 8'hAA;

  // Word loaded into a location during initialisation; everything not in the
  // table starts at zero.
  function automatic logic [7:0] preset_val(input logic [7:0] addr);
    logic [7:0] val;
    val = 8'h00;
    if (addr == {3'b000, ADDR_DATA_1}) val = VAL_DATA_1;
    if (addr == {3'b000, ADDR_DATA_2}) val = VAL_DATA_2;
    if (addr == {3'b000, ADDR_TEMP})   val = VAL_TEMP;
    return val;
  endfunction

endpackage

// File: rtl/data_mem_init_seq.sv
// Initialisation sequencer: walks every word address once after reset, then
// parks in IDLE and reports ready. Only reset brings it back to INIT.
module data_mem_init_seq
  import data_mem_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_we_o,
  output logic [ADDR_W-1:0] cnt_o,
  output logic              ready_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Next state: count through the array; the edge that writes the last word
  // also moves to IDLE so ready rises exactly DEPTH edges after release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      if (cnt_q == LAST_ADDR) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end
  end

  // State and counter registers; asynchronous reset aborts any INIT in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign init_we_o = (state_q == ST_INIT);
  assign cnt_o     = cnt_q;
  assign ready_o   = (state_q == ST_IDLE);

endmodule

// File: rtl/data_mem_seq.sv
// Parametrised data memory with registered read and self-initialisation.
// Optional feature macro: DATA_MEM_PARITY_EN adds an even-parity bit per
// word, an inj_par write hook and a registered par_err flag.
module data_mem_seq
  import data_mem_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              ready,
  output logic              addr_err
`ifdef DATA_MEM_PARITY_EN
  ,
  input  logic              inj_par,
  output logic              par_err
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic              init_we;
  logic [ADDR_W-1:0] init_cnt;
  logic              ready_s;

  logic              addr_ok;
  logic              acc_rd;
  logic              acc_any;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_word;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              addr_err_q, addr_err_d;

  data_mem_init_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_init_seq (
    .clock     (clock),
    .reset     (reset),
    .init_we_o (init_we),
    .cnt_o     (init_cnt),
    .ready_o   (ready_s)
  );

  assign addr_ok = ({1'b0, addr} < DEPTH_C);
  assign acc_rd  = ready_s & rd_en;
  assign acc_any = ready_s & (rd_en | wr_en);
  assign rd_word = addr_ok ? mem_q[addr] : '0;

  // Write port mux: the sequencer owns the array during INIT, the CPU after.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = wdata;
    if (init_we) begin
      mem_we    = 1'b1;
      mem_waddr = init_cnt;
      mem_wdata = DATA_W'(preset_val(8'(init_cnt)));
    end else if (ready_s && wr_en && addr_ok) begin
      mem_we = 1'b1;
    end
  end

  // Storage array; not reset, contents become defined once INIT has run.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Read/error next state: out-of-range reads return zero but still report
  // valid; rdata holds when no read is accepted.
  always_comb begin
    rdata_d       = rdata_q;
    rdata_valid_d = acc_rd;
    addr_err_d    = acc_any & ~addr_ok;
    if (acc_rd) rdata_d = rd_word;
  end

  // Registered read data and status flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      addr_err_q    <= addr_err_d;
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign ready       = ready_s;
  assign addr_err    = addr_err_q;

`ifdef DATA_MEM_PARITY_EN
  logic par_mem_q [DEPTH];
  logic par_wbit;
  logic par_err_q, par_err_d;

  // Even parity over the written word; the injection hook only applies to
  // CPU writes, never to the preset load.
  assign par_wbit = (^mem_wdata) ^ (~init_we & inj_par);

  // Parity storage alongside the data array.
  always_ff @(posedge clock) begin
    if (mem_we) par_mem_q[mem_waddr] <= par_wbit;
  end

  // Parity check computed on the same read that loads rdata.
  always_comb begin
    par_err_d = par_err_q;
    if (acc_rd) par_err_d = addr_ok & ((^mem_q[addr]) ^ par_mem_q[addr]);
  end

  // Registered parity error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) par_err_q <= 1'b0;
    else        par_err_q <= par_err_d;
  end

  assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_data_mem_seq.sv
// Directed self-checking bench: a 32-word instance for init, read/write,
// read-first and reset-abort behaviour, and a 20-word instance for range
// errors. Parity steps are compiled in with DATA_MEM_PARITY_EN.
module tb_data_mem_seq;

  logic       clock;
  logic       reset;

  logic       wr_a, rd_a;
  logic [4:0] addr_a;
  logic [7:0] wdata_a;
  logic [7:0] rdata_a;
  logic       valid_a, ready_a, aerr_a;

  logic       wr_b, rd_b;
  logic [4:0] addr_b;
  logic [7:0] wdata_b;
  logic [7:0] rdata_b;
  logic       valid_b, ready_b, aerr_b;

`ifdef DATA_MEM_PARITY_EN
  logic inj_a, perr_a, inj_b, perr_b;
`endif

  int errors;
  int checks;
  int na, nb;

  data_mem_seq #(.DATA_W(8), .DEPTH(32)) dut_a (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_a),
    .rd_en       (rd_a),
    .addr        (addr_a),
    .wdata       (wdata_a),
    .rdata       (rdata_a),
    .rdata_valid (valid_a),
    .ready       (ready_a),
    .addr_err    (aerr_a)
`ifdef DATA_MEM_PARITY_EN
    ,
    .inj_par     (inj_a),
    .par_err     (perr_a)
`endif
  );

  data_mem_seq #(.DATA_W(8), .DEPTH(20)) dut_b (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_b),
    .rd_en       (rd_b),
    .addr        (addr_b),
    .wdata       (wdata_b),
    .rdata       (rdata_b),
    .rdata_valid (valid_b),
    .ready       (ready_b),
    .addr_err    (aerr_b)
`ifdef DATA_MEM_PARITY_EN
    ,
    .inj_par     (inj_b),
    .par_err     (perr_b)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    wr_a = 0; rd_a = 0; addr_a = '0; wdata_a = '0;
    wr_b = 0; rd_b = 0; addr_b = '0; wdata_b = '0;
`ifdef DATA_MEM_PARITY_EN
    inj_a = 0; inj_b = 0;
`endif

    // Reset state
    step();
    step();
    chk("rst_rdata", 32'(rdata_a), 32'h00);
    chk("rst_valid", 32'(valid_a), 32'h0);
    chk("rst_ready", 32'(ready_a), 32'h0);
    chk("rst_aerr",  32'(aerr_a),  32'h0);

    // First INIT, aborted at cycle 10
    reset = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("init1_ready", 32'(ready_a), 32'h0);
    chk("init1_valid", 32'(valid_a), 32'h0);
    reset = 1'b0;
    #2;
    chk("abort_ready", 32'(ready_a), 32'h0);
    step();
    reset = 1'b1;

    // Second INIT: count edges to ready; a write to 0x00 mid-INIT must be ignored
    na = 0;
    nb = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (ready_a && na == 0) na = i;
      if (ready_b && nb == 0) nb = i;
      if (i == 5) begin wr_a = 1; rd_a = 1; addr_a = 5'h00; wdata_a = 8'hFF; end
      if (i == 6) begin wr_a = 0; rd_a = 0; end
      if (i == 10) chk("init2_valid", 32'(valid_a), 32'h0);
    end
    chk("ready_edges_32", 32'(na), 32'd32);
    chk("ready_edges_20", 32'(nb), 32'd20);

    // Preset reads
    rd_a = 1; addr_a = 5'h1A; step();
    chk("rd_1A", 32'(rdata_a), 32'h00);
    chk("rd_1A_valid", 32'(valid_a), 32'h1);
    chk("rd_1A_aerr", 32'(aerr_a), 32'h0);
    addr_a = 5'h1B; step();
    chk("rd_1B", 32'(rdata_a), 32'hFF);
    addr_a = 5'h1C; step();
    chk("rd_1C", 32'(rdata_a), 32'hAA);
    addr_a = 5'h05; step();
    chk("rd_05", 32'(rdata_a), 32'h00);
    addr_a = 5'h00; step();
    chk("rd_00_after_init_wr", 32'(rdata_a), 32'h00);
    rd_a = 0;

    // Write then read
    wr_a = 1; addr_a = 5'h1C; wdata_a = 8'h5A; step();
    wr_a = 0; rd_a = 1; step();
    chk("wr_rd_1C", 32'(rdata_a), 32'h5A);
    chk("wr_rd_1C_valid", 32'(valid_a), 32'h1);
    rd_a = 0; step();
    chk("idle_valid", 32'(valid_a), 32'h0);
    chk("idle_hold", 32'(rdata_a), 32'h5A);

    // Read-first
    wr_a = 1; rd_a = 1; addr_a = 5'h1B; wdata_a = 8'h3C; step();
    chk("rf_old", 32'(rdata_a), 32'hFF);
    chk("rf_valid", 32'(valid_a), 32'h1);
    wr_a = 0; step();
    chk("rf_new", 32'(rdata_a), 32'h3C);
    rd_a = 0;

    // Range checks on the 20-word instance
    wr_b = 1; addr_b = 5'h03; wdata_b = 8'h77; step();
    wr_b = 0; rd_b = 1; step();
    chk("b_rd_03", 32'(rdata_b), 32'h77);
    chk("b_rd_03_aerr", 32'(aerr_b), 32'h0);
    addr_b = 5'h17; step();
    chk("b_rd_17", 32'(rdata_b), 32'h00);
    chk("b_rd_17_valid", 32'(valid_b), 32'h1);
    chk("b_rd_17_aerr", 32'(aerr_b), 32'h1);
    rd_b = 0; step();
    chk("b_aerr_pulse", 32'(aerr_b), 32'h0);
    wr_b = 1; addr_b = 5'h17; wdata_b = 8'h99; step();
    chk("b_wr_17_aerr", 32'(aerr_b), 32'h1);
    chk("b_wr_17_valid", 32'(valid_b), 32'h0);
    wr_b = 0; rd_b = 1; addr_b = 5'h03; step();
    chk("b_03_unchanged", 32'(rdata_b), 32'h77);
    chk("b_03_aerr", 32'(aerr_b), 32'h0);
    rd_b = 0;

`ifdef DATA_MEM_PARITY_EN
    // Parity injection and repair
    wr_a = 1; inj_a = 1; addr_a = 5'h02; wdata_a = 8'h81; step();
    wr_a = 0; inj_a = 0; rd_a = 1; step();
    chk("par_inj", 32'(perr_a), 32'h1);
    chk("par_inj_data", 32'(rdata_a), 32'h81);
    rd_a = 0; wr_a = 1; step();
    wr_a = 0; rd_a = 1; step();
    chk("par_clean", 32'(perr_a), 32'h0);
    addr_a = 5'h1C; step();
    chk("par_1C", 32'(perr_a), 32'h0);
    rd_a = 0;
`endif

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
